lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Host-side command initiator for the image display controller: it drives cmd/cmd_valid and obeys busy/done.
//  Fetches 4-bit opcodes from a synchronous script ROM and issues each one to the controller.
//  Sits between test/system control and the display controller; replaces hand-driven cmd stimulus.
// PARAMETERS
//  ADDR_W     5     script ROM address width; script depth = 2**ADDR_W entries
//  TIMEOUT    1024  watchdog limit in cycles (used only with LCD_SEQ_TIMEOUT_EN)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high
//  start       in   1       pulse; begins a script run from address 0 (ignored while running)
//  scr_rd      out  1       script ROM read enable
//  scr_A       out  ADDR_W  script ROM address
//  scr_Q       in   4       script ROM data, valid 1 cycle after scr_rd
//  busy        in   1       controller busy
//  done        in   1       controller done (image write-back complete)
//  cmd         out  4       opcode to controller
//  cmd_valid   out  1       1-cycle strobe qualifying cmd
//  running     out  1       high from accepted start until script end
//  finished    out  1       1-cycle pulse at script end
//  cmd_count   out  ADDR_W+1 number of commands issued in current/last run
//  err         out  1       sticky watchdog error; cleared by start (tied 0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0, scr_A=0, state IDLE, counters 0.
//  States: IDLE -> FETCH -> WAIT_Q -> ISSUE -> WAIT_ACK -> WAIT_RDY [-> WAIT_DONE] -> FETCH | END -> IDLE.
//  IDLE: on start=1, running<=1, scr_A<=0, cmd_count<=0, err<=0, go FETCH.
//  FETCH: scr_rd=1 for exactly 1 cycle; WAIT_Q: latch scr_Q into opcode register.
//  Opcode 4'hF (terminator), 4'hD, 4'hE are not issued: go END.
//  ISSUE: held until busy==0; then cmd=opcode, cmd_valid=1 for exactly 1 cycle, cmd_count++.
//  WAIT_ACK: skip exactly 1 cycle (controller registers busy one cycle late).
//  WAIT_RDY: wait busy==0. If opcode==4'h0 (Write) go WAIT_DONE, else scr_A++ and FETCH.
//  WAIT_DONE: wait done==1, then END (Write ends the image flow).
//  scr_A wrap: after entry 2**ADDR_W-1 is issued, go END instead of wrapping to 0.
//  END: finished=1 for 1 cycle, running<=0, back to IDLE; cmd_count held until next start.
//  start while running: ignored. Reset mid-run: immediate return to IDLE; no cmd_valid is produced.
//  cmd holds the last issued value between strobes; only cmd_valid is qualified.
//  Latency: start -> first cmd_valid = 3 cycles when busy==0.
// CONFIGURATION
//  LCD_SEQ_TIMEOUT_EN defined: a watchdog counter clears on entry to ISSUE/WAIT_RDY/WAIT_DONE.
//  It counts while one of those states waits. At count==TIMEOUT-1: err<=1, then END (finished pulses).
//  LCD_SEQ_TIMEOUT_EN undefined: no counter is built, err is tied 0, and waits are unbounded.
// STRUCTURE
//  Package lcd_cmd_pkg holds:
//   - opcode localparams: WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, MAX=5,
//     MIN=6, AVERAGE=7, CCW=8, CW=9, MIRROR_X=10, MIRROR_Y=11, LOAD=12, TERM=15;
//   - sequencer state encoding.
//  Sub-module lcd_seq_watchdog (counter + compare), instantiated only under LCD_SEQ_TIMEOUT_EN.
// TESTING
//  1 Script {3,5,0,F}, busy low except 4 cycles after each strobe, done 10 cycles after Write:
//    -> exactly 3 strobes with cmd 3,5,0, cmd_count=3, and finished 1 cycle after done.
//  2 busy held 1 for 20 cycles when ISSUE is reached -> cmd_valid stays 0 until the cycle after busy falls.
//  3 Script {F} -> no cmd_valid; finished pulses 3 cycles after start; cmd_count=0.
//  4 32 non-terminating, non-Write opcodes -> 32 strobes, then END without wrap; cmd_count=32.
//  5 Reset asserted in WAIT_RDY -> all outputs 0 the same cycle; a later start restarts at scr_A=0.
//  6 With LCD_SEQ_TIMEOUT_EN and TIMEOUT=16, busy stuck 1 -> err=1 and finished after 16 waiting cycles.
//    A new start clears err.

Source files
------------

// File: rtl/lcd_cmd_pkg.sv
// Opcode map and sequencer state type shared by the LCD command sequencer files.
// The optional watchdog is enabled with the LCD_SEQ_TIMEOUT_EN macro.
package lcd_cmd_pkg;

    localparam logic [3:0] WRITE       = 4'h0;
    localparam logic [3:0] SHIFT_UP    = 4'h1;
    localparam logic [3:0] SHIFT_DOWN  = 4'h2;
    localparam logic [3:0] SHIFT_LEFT  = 4'h3;
    localparam logic [3:0] SHIFT_RIGHT = 4'h4;
    localparam logic [3:0] MAX         = 4'h5;
    localparam logic [3:0] MIN         = 4'h6;
    localparam logic [3:0] AVERAGE     = 4'h7;
    localparam logic [3:0] CCW         = 4'h8;
    localparam logic [3:0] CW          = 4'h9;
    localparam logic [3:0] MIRROR_X    = 4'hA;
    localparam logic [3:0] MIRROR_Y    = 4'hB;
    localparam logic [3:0] LOAD        = 4'hC;
    localparam logic [3:0] TERM        = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_Q,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_RDY,
        S_WAIT_DONE,
        S_END
    } seq_state_t;

    // 4'hD and 4'hE are reserved and end the script just like the terminator.
    function automatic logic is_stop_op(input logic [3:0] op);
        return (op == TERM) || (op == 4'hD) || (op == 4'hE);
    endfunction

endpackage

// File: rtl/lcd_seq_watchdog.sv
// Wait-state watchdog: counts waiting cycles and flags when the limit is reached.
// Only instantiated when LCD_SEQ_TIMEOUT_EN is defined.
module lcd_seq_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] r_count;

    // Ungated compare; the sequencer only acts on it while waiting.
    assign o_expired = (r_count == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Script-driven command initiator for the image display controller.
// Define LCD_SEQ_TIMEOUT_EN to build the wait-state watchdog and the err flag.
module lcd_cmd_sequencer
    import lcd_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              scr_rd,
    output logic [ADDR_W-1:0] scr_A,
    input  logic [3:0]        scr_Q,
    input  logic              busy,
    input  logic              done,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    output logic              running,
    output logic              finished,
    output logic [ADDR_W:0]   cmd_count,
    output logic              err
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [3:0]        r_opcode;
    logic [3:0]        r_cmd;
    logic [ADDR_W-1:0] r_scr_A;
    logic [ADDR_W:0]   r_cmd_count;
    logic              r_running;

    logic w_start_acc;
    logic w_strobe;
    logic w_addr_inc;
    logic w_finished;
    logic w_rd;
    logic w_timeout;

    assign w_start_acc = (r_state == S_IDLE) && start;

`ifdef LCD_SEQ_TIMEOUT_EN
    logic w_waiting;
    logic w_wd_clear;
    logic r_err;

    assign w_waiting  = ((r_state == S_ISSUE)     && busy) ||
                        ((r_state == S_WAIT_RDY)  && busy) ||
                        ((r_state == S_WAIT_DONE) && !done);
    // Any state change restarts the count, which covers entry into each wait state.
    assign w_wd_clear = (w_next != r_state);

    lcd_seq_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clear),
        .i_count  (w_waiting),
        .o_expired(w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_waiting && w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_rd       = 1'b0;
        w_strobe   = 1'b0;
        w_addr_inc = 1'b0;
        w_finished = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_rd   = 1'b1;
                w_next = S_WAIT_Q;
            end
            S_WAIT_Q: begin
                w_next = is_stop_op(scr_Q) ? S_END : S_ISSUE;
            end
            S_ISSUE: begin
                if (!busy) begin
                    w_strobe = 1'b1;
                    w_next   = S_WAIT_ACK;
                end else if (w_timeout) begin
                    w_next = S_END;
                end
            end
            S_WAIT_ACK: begin
                w_next = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!busy) begin
                    if (r_opcode == WRITE) begin
                        w_next = S_WAIT_DONE;
                    end else if (r_scr_A == '1) begin
                        w_next = S_END;
                    end else begin
                        w_addr_inc = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = S_END;
                end
            end
            S_WAIT_DONE: begin
                if (done || w_timeout) w_next = S_END;
            end
            S_END: begin
                w_finished = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_cmd       <= '0;
            r_scr_A     <= '0;
            r_cmd_count <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_running   <= 1'b1;
                r_scr_A     <= '0;
                r_cmd_count <= '0;
            end
            if (r_state == S_WAIT_Q) begin
                r_opcode <= scr_Q;
            end
            if (w_strobe) begin
                r_cmd       <= r_opcode;
                r_cmd_count <= r_cmd_count + 1'b1;
            end
            if (w_addr_inc) begin
                r_scr_A <= r_scr_A + 1'b1;
            end
            if (r_state == S_END) begin
                r_running <= 1'b0;
            end
        end
    end

    // The strobe cycle shows the new opcode; otherwise cmd holds the last issued one.
    assign cmd       = w_strobe ? r_opcode : r_cmd;
    assign cmd_valid = w_strobe;
    assign scr_rd    = w_rd;
    assign scr_A     = r_scr_A;
    assign running   = r_running;
    assign finished  = w_finished;
    assign cmd_count = r_cmd_count;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: ROM and controller models plus script-level reference.
// Define LCD_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_lcd_cmd_sequencer;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int FORCE_LEN = 12;
`else
    localparam int FORCE_LEN = 20;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          scr_rd;
    logic [AW-1:0] scr_A;
    logic [3:0]    scr_Q;
    logic          busy;
    logic          done;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          running;
    logic          finished;
    logic [AW:0]   cmd_count;
    logic          err;

    lcd_cmd_sequencer #(
        .ADDR_W (AW),
        .TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .scr_rd   (scr_rd),
        .scr_A    (scr_A),
        .scr_Q    (scr_Q),
        .busy     (busy),
        .done     (done),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .running  (running),
        .finished (finished),
        .cmd_count(cmd_count),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ops [4];
        int         lat_busy;
        int         lat_done;
        int         mid_start;
        int         exp_n;
        int         exp_fin;
    } vec_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         k = 0;
    logic [3:0] rom [DEPTH];
    int         cur_L = 0, cur_D = 3, f_lo = -1, f_hi = -2;
    int         busy_rem = 0, done_rem = 0;
    bit         p_valid = 0, p_rd = 0;
    logic [3:0] p_cmd = '0;
    logic [AW-1:0] p_addr = '0;
    bit         start_req = 0;
    logic [3:0] strobes [$];
    int         strobe_cyc [$];
    int         rd_addr [$];
    logic [3:0] exp_q [$];
    int         exp_rd;
    int         fin_cnt, fin_cyc, done_cyc, start_cyc;
    int         probe_cyc = -1;
    logic [3:0] probe_cmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    // One clock: drive ROM/controller inputs at the falling edge, then sample outputs.
    task automatic tick();
        @(negedge clk);
        k++;
        if (p_valid) begin
            busy_rem = cur_L;
            if (p_cmd == 4'h0) done_rem = cur_D;
        end
        busy = (busy_rem != 0) || (k >= f_lo && k <= f_hi);
        if (busy_rem != 0) busy_rem--;
        done = (done_rem == 1);
        if (done_rem != 0) done_rem--;
        if (p_rd) scr_Q = rom[p_addr];
        start = start_req;
        start_req = 0;
        #1;
        p_valid = cmd_valid;
        p_cmd   = cmd;
        p_rd    = scr_rd;
        p_addr  = scr_A;
        if (cmd_valid) begin
            strobes.push_back(cmd);
            strobe_cyc.push_back(k);
        end
        if (scr_rd) rd_addr.push_back(int'(scr_A));
        if (done) done_cyc = k;
        if (finished) begin
            fin_cnt++;
            fin_cyc = k;
        end
        if (k == probe_cyc) probe_cmd = cmd;
    endtask

    task automatic clear_mon();
        fin_cnt = 0;
        fin_cyc = -100;
        done_cyc = -100;
        strobes.delete();
        strobe_cyc.delete();
        rd_addr.delete();
    endtask

    task automatic run_script(input int mid_off);
        clear_mon();
        start_cyc = k + 1;
        start_req = 1;
        for (int i = 0; i < 2000 && fin_cnt == 0; i++) begin
            if (mid_off > 0 && k + 1 == start_cyc + mid_off) start_req = 1;
            tick();
        end
        tick();
        tick();
        chk("finished_pulses", fin_cnt, 1);
        chk("running_after_end", running, 0);
    endtask

    // Reference: walk the script from address 0 until a stop opcode, a Write, or the last entry.
    task automatic build_expect();
        exp_q.delete();
        exp_rd = 0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_rd++;
            if (rom[a] == 4'hD || rom[a] == 4'hE || rom[a] == 4'hF) break;
            exp_q.push_back(rom[a]);
            if (rom[a] == 4'h0) break;
        end
    endtask

    task automatic check_run(input string tag, input bit lat_chk);
        build_expect();
        chk({tag, "_strobes"}, strobes.size(), exp_q.size());
        for (int i = 0; i < strobes.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_cmd%0d", tag, i), strobes[i], exp_q[i]);
        chk({tag, "_cmd_count"}, cmd_count, exp_q.size());
        chk({tag, "_fetches"}, rd_addr.size(), exp_rd);
        for (int i = 0; i < rd_addr.size(); i++)
            if (rd_addr[i] != i) chk($sformatf("%s_addr%0d", tag, i), rd_addr[i], i);
        if (exp_q.size() > 0) begin
            chk({tag, "_cmd_hold"}, cmd, exp_q[exp_q.size() - 1]);
            if (lat_chk) chk({tag, "_first_lat"}, strobe_cyc[0] - start_cyc, 3);
            if (exp_q[exp_q.size() - 1] == 4'h0)
                chk({tag, "_fin_after_done"}, fin_cyc - done_cyc, 1);
        end
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic fill_rom(input logic [3:0] v);
        for (int a = 0; a < DEPTH; a++) rom[a] = v;
    endtask

    vec_t tbl [8];

    task automatic set_row(input int i, input logic [3:0] o0, input logic [3:0] o1,
                           input logic [3:0] o2, input logic [3:0] o3, input int L,
                           input int D, input int mid, input int n, input int fin);
        tbl[i].ops[0] = o0; tbl[i].ops[1] = o1; tbl[i].ops[2] = o2; tbl[i].ops[3] = o3;
        tbl[i].lat_busy = L; tbl[i].lat_done = D; tbl[i].mid_start = mid;
        tbl[i].exp_n = n; tbl[i].exp_fin = fin;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; busy = 1'b0; done = 1'b0; scr_Q = '0;
        fill_rom(4'hF);
        // Finished latency: 3 for a bare stop, plus 4+max(1,L) per issued non-Write command.
        set_row(0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 3, 0, 0, 3);
        set_row(1, 4'hD, 4'hF, 4'hF, 4'hF, 0, 3, 0, 0, 3);
        set_row(2, 4'hE, 4'hF, 4'hF, 4'hF, 0, 3, 0, 0, 3);
        set_row(3, 4'h7, 4'h9, 4'hE, 4'hF, 0, 3, 0, 2, 13);
        set_row(4, 4'h1, 4'h2, 4'h3, 4'hF, 2, 3, 0, 3, 21);
        set_row(5, 4'h3, 4'h5, 4'h0, 4'hF, 4, 10, 6, 3, 30);
        set_row(6, 4'h0, 4'h7, 4'hF, 4'hF, 1, 5, 0, 1, 9);
        set_row(7, 4'hC, 4'hB, 4'hA, 4'hF, 1, 3, 0, 3, 18);

        repeat (3) tick();
        chk("rst_running", running, 0);
        chk("rst_scr_rd", scr_rd, 0);
        chk("rst_scr_A", scr_A, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_finished", finished, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            fill_rom(4'hF);
            for (int j = 0; j < 4; j++) rom[j] = tbl[r].ops[j];
            cur_L = tbl[r].lat_busy;
            cur_D = tbl[r].lat_done;
            run_script(tbl[r].mid_start);
            chk($sformatf("row%0d_n", r), strobes.size(), tbl[r].exp_n);
            chk($sformatf("row%0d_fin_lat", r), fin_cyc - start_cyc, tbl[r].exp_fin);
            check_run($sformatf("row%0d", r), 1'b1);
        end

        // Busy held high when ISSUE is reached: strobe only once busy drops, cmd held meanwhile.
        fill_rom(4'hF);
        rom[0] = 4'h4;
        cur_L = 0;
        f_lo = k + 1 + 3;
        f_hi = f_lo + FORCE_LEN - 1;
        probe_cyc = f_lo + 5;
        begin
            logic [3:0] prev_cmd;
            prev_cmd = cmd;
            run_script(0);
            chk("hold_probe_cmd", probe_cmd, prev_cmd);
        end
        chk("hold_strobe_cycle", strobe_cyc.size() > 0 ? strobe_cyc[0] - start_cyc : -1, 3 + FORCE_LEN);
        check_run("hold", 1'b0);
        f_lo = -1; f_hi = -2; probe_cyc = -1;

        // Full-depth script of issued opcodes ends without wrapping.
        for (int a = 0; a < DEPTH; a++) rom[a] = 4'($urandom_range(1, 12));
        cur_L = int'($urandom_range(0, 3));
        run_script(0);
        chk("full_strobes", strobes.size(), DEPTH);
        chk("full_cmd_count", cmd_count, DEPTH);
        check_run("full", 1'b1);

        // Reset asserted while waiting for busy to drop.
        fill_rom(4'hF);
        rom[0] = 4'h3; rom[1] = 4'h6;
        cur_L = 6;
        clear_mon();
        start_cyc = k + 1;
        start_req = 1;
        for (int i = 0; i < 50 && strobes.size() == 0; i++) tick();
        tick();
        tick();
        chk("pre_reset_running", running, 1);
        chk("pre_reset_cmd_count", cmd_count, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_running", running, 0);
        chk("mid_reset_cmd", cmd, 0);
        chk("mid_reset_cmd_count", cmd_count, 0);
        chk("mid_reset_scr_rd", scr_rd, 0);
        chk("mid_reset_cmd_valid", cmd_valid, 0);
        chk("mid_reset_finished", finished, 0);
        tick();
        tick();
        reset = 1'b0;
        busy_rem = 0;
        done_rem = 0;
        tick();
        chk("reset_no_extra_strobe", strobes.size(), 1);
        fill_rom(4'hF);
        rom[0] = 4'h9; rom[1] = 4'h2;
        cur_L = 0;
        run_script(0);
        check_run("after_reset", 1'b1);

        // Randomized scripts against the reference walk.
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int unsigned r;
                r = $urandom_range(0, 99);
                if (r < 8)       rom[a] = 4'h0;
                else if (r < 14) rom[a] = 4'($urandom_range(13, 15));
                else             rom[a] = 4'($urandom_range(1, 12));
            end
            cur_L = int'($urandom_range(0, 5));
            cur_D = cur_L + 3 + int'($urandom_range(0, 6));
            run_script(0);
            check_run($sformatf("rand%0d", t), 1'b1);
        end

`ifdef LCD_SEQ_TIMEOUT_EN
        // Busy stuck high: 16 waiting cycles in ISSUE, then err and END.
        fill_rom(4'hF);
        rom[0] = 4'h4;
        cur_L = 0;
        f_lo = k + 1 + 3;
        f_hi = f_lo + 1000;
        run_script(0);
        chk("wd_strobes", strobes.size(), 0);
        chk("wd_fin_lat", fin_cyc - start_cyc, 19);
        chk("wd_err_set", err, 1);
        f_lo = -1; f_hi = -2;
        run_script(0);
        check_run("wd_clear", 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
